// File: rtl/iob_req_reg.sv
// -----------------------------------------------------------------------------
// iob_req_reg
//
// Registered IOb pipeline stage placed between the Wishbone-to-IOb bridge and
// the IOb memory/peripheral interconnect. One request is captured from the
// upstream side and driven downstream until the slave answers. The answer is
// then returned upstream as a one-cycle ready pulse. Every output comes
// straight from a flop, so no combinational path crosses this stage.
//
// Optional feature (compile-time macro IOB_REQ_TIMEOUT_EN):
//   When defined, a watchdog counts REQ cycles without ready_i. After TIMEOUT
//   such cycles the access is abandoned and answered upstream with err_o=1
//   and rdata_o=0. When undefined, there is no counter, REQ waits forever
//   and err_o is tied to 0.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width (multiple of 8); strobe width is DATA_W/8
//   TIMEOUT_W  watchdog counter width
//   TIMEOUT    REQ cycles without ready_i before abort (1..2**TIMEOUT_W-1)
//
// Ports
//   clk_i    in   clock, all logic on rising edge
//   rst_i    in   synchronous active-high reset
//   valid_i  in   upstream request valid
//   addr_i   in   upstream address
//   wdata_i  in   upstream write data
//   wstrb_i  in   upstream write strobes (all zero = read)
//   rdata_o  out  upstream read data, valid while ready_o=1, held afterwards
//   ready_o  out  upstream response, one-cycle pulse
//   err_o    out  upstream error flag, valid while ready_o=1
//   valid_o  out  downstream request valid
//   addr_o   out  downstream address (registered)
//   wdata_o  out  downstream write data (registered)
//   wstrb_o  out  downstream write strobes (registered)
//   rdata_i  in   downstream read data, sampled when ready_i=1
//   ready_i  in   downstream response
// -----------------------------------------------------------------------------
module iob_req_reg #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // upstream (bridge) side
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                err_o,
  // downstream (interconnect) side
  output logic                valid_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

  localparam int STRB_W = DATA_W / 8;

  // Elaboration-time configuration guard: an out-of-range TIMEOUT or a data
  // width that is not a whole number of bytes shows up as this named block in
  // the elaborated hierarchy.
  if ((TIMEOUT < 1) || (TIMEOUT > (2 ** TIMEOUT_W) - 1) || ((DATA_W % 8) != 0))
  begin : g_bad_config
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Read data returned upstream: a write (any strobe set) answers with zero
  // so the bridge never sees stale slave data on a write acknowledge.
  function automatic logic [DATA_W-1:0] resp_data(input logic [STRB_W-1:0] strb,
                                                  input logic [DATA_W-1:0] rdata);
    resp_data = (|strb) ? '0 : rdata;
  endfunction

`ifdef IOB_REQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // A reset in REQ simply drops the access; nothing is ever answered.
      state   <= IDLE;
      valid_o <= 1'b0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      wstrb_o <= '0;
      rdata_o <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        // IDLE: accept a new request; ready_i here is spurious and ignored.
        IDLE: begin
          if (valid_i) begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            wstrb_o <= wstrb_i;
            valid_o <= 1'b1;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        // REQ: hold the request stable; valid_i is ignored so an upstream
        // drop cannot abort a downstream access. A slave answer in the same
        // cycle as the watchdog expiry wins over the abort.
        REQ: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            rdata_o <= resp_data(wstrb_o, rdata_i);
            err_o   <= 1'b0;
            ready_o <= 1'b1;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            valid_o <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b1;
            ready_o <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // RESP: the ready pulse lasts exactly this cycle; rdata_o is kept.
        RESP: begin
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b0;
          err_o   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
`else
  // Without the watchdog an error can never be produced.
  assign err_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // A reset in REQ simply drops the access; nothing is ever answered.
      state   <= IDLE;
      valid_o <= 1'b0;
      ready_o <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      wstrb_o <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        // IDLE: accept a new request; ready_i here is spurious and ignored.
        IDLE: begin
          if (valid_i) begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            wstrb_o <= wstrb_i;
            valid_o <= 1'b1;
            state   <= REQ;
          end
        end
        // REQ: hold the request stable and wait for the slave indefinitely;
        // valid_i is ignored so an upstream drop cannot abort the access.
        REQ: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            rdata_o <= resp_data(wstrb_o, rdata_i);
            ready_o <= 1'b1;
            state   <= RESP;
          end
        end
        // RESP: the ready pulse lasts exactly this cycle; rdata_o is kept.
        RESP: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_iob_req_reg.sv
// -----------------------------------------------------------------------------
// tb_iob_req_reg
//
// Directed bench for iob_req_reg. Inputs are driven 1 ns after each rising
// edge; outputs are checked at that same point, i.e. they show the state
// registered by the edge just passed. Covers reset, read, write with wait
// states, back-to-back reads, spurious ready, reset mid-access and either the
// watchdog (IOB_REQ_TIMEOUT_EN, TIMEOUT=4) or the absence of any timeout.
// -----------------------------------------------------------------------------
module tb_iob_req_reg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
`ifdef IOB_REQ_TIMEOUT_EN
  localparam int WR_WAIT = 2;   // stay below the 4-cycle watchdog
`else
  localparam int WR_WAIT = 5;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ready_o;
  logic              err_o;
  logic              valid_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic [DATA_W-1:0] rdata_i;
  logic              ready_i;

  int n_vec = 0;
  int n_err = 0;
  int req_edges = 0;     // downstream requests seen (valid_o rising)
  int resp_pulses = 0;   // upstream ready_o cycles seen
  logic valid_q = 1'b0;
  int base_req;
  int base_resp;

  iob_req_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TIMEOUT_W(8),
    .TIMEOUT  (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .wstrb_i(wstrb_i),
    .rdata_o(rdata_o),
    .ready_o(ready_o),
    .err_o  (err_o),
    .valid_o(valid_o),
    .addr_o (addr_o),
    .wdata_o(wdata_o),
    .wstrb_o(wstrb_o),
    .rdata_i(rdata_i),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  // Transaction monitor, sampled mid-cycle.
  always @(negedge clk) begin
    valid_q <= valid_o;
    if (valid_o && !valid_q) req_edges <= req_edges + 1;
    if (ready_o) resp_pulses <= resp_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    wstrb_i = '0;
    rdata_i = '0;
    ready_i = 1'b0;
    tick();
    tick();
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_err_o",   64'(err_o),   64'd0);
    chk("rst_addr_o",  64'(addr_o),  64'd0);
    chk("rst_rdata_o", 64'(rdata_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // ---- 1: single read, ready_i on second REQ cycle ----
    valid_i = 1'b1; addr_i = 32'h100; wstrb_i = '0; wdata_i = 32'h0;
    tick();                                   // t1
    chk("rd_valid_t1", 64'(valid_o), 64'd1);
    chk("rd_addr_t1",  64'(addr_o),  64'h100);
    chk("rd_ready_t1", 64'(ready_o), 64'd0);
    tick();                                   // t2
    chk("rd_valid_t2", 64'(valid_o), 64'd1);
    chk("rd_ready_t2", 64'(ready_o), 64'd0);
    ready_i = 1'b1; rdata_i = 32'hDEADBEEF;
    tick();                                   // t3
    chk("rd_ready_t3", 64'(ready_o), 64'd1);
    chk("rd_rdata_t3", 64'(rdata_o), 64'hDEADBEEF);
    chk("rd_err_t3",   64'(err_o),   64'd0);
    chk("rd_valid_t3", 64'(valid_o), 64'd0);
    valid_i = 1'b0; ready_i = 1'b0; rdata_i = '0;
    tick();                                   // t4
    chk("rd_ready_t4", 64'(ready_o), 64'd0);
    chk("rd_rdata_hold", 64'(rdata_o), 64'hDEADBEEF);

    // ---- 6: spurious ready_i in IDLE ----
    ready_i = 1'b1; rdata_i = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_ready_o", 64'(ready_o), 64'd0);
      chk("spur_valid_o", 64'(valid_o), 64'd0);
      chk("spur_rdata_o", 64'(rdata_o), 64'hDEADBEEF);
    end
    ready_i = 1'b0; rdata_i = '0;

    // ---- 2: write with wait states, upstream inputs change mid-access ----
    valid_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678; wstrb_i = 4'b0011;
    tick();
    valid_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = 32'hA5A5A5A5; wstrb_i = 4'b1111;
    for (int i = 0; i <= WR_WAIT; i++) begin
      chk("wr_valid_o", 64'(valid_o), 64'd1);
      chk("wr_addr_o",  64'(addr_o),  64'h20);
      chk("wr_wdata_o", 64'(wdata_o), 64'h12345678);
      chk("wr_wstrb_o", 64'(wstrb_o), 64'h3);
      chk("wr_ready_wait", 64'(ready_o), 64'd0);
      if (i == WR_WAIT) begin
        ready_i = 1'b1; rdata_i = 32'hCAFEF00D;
      end
      tick();
    end
    ready_i = 1'b0; rdata_i = '0;
    chk("wr_ready_o", 64'(ready_o), 64'd1);
    chk("wr_rdata_o", 64'(rdata_o), 64'd0);
    chk("wr_err_o",   64'(err_o),   64'd0);
    chk("wr_valid_done", 64'(valid_o), 64'd0);
    tick();
    chk("wr_ready_end", 64'(ready_o), 64'd0);

    // ---- 3: back-to-back reads 0x0 and 0x4 ----
    base_req  = req_edges;
    base_resp = resp_pulses;
    for (int k = 0; k < 2; k++) begin
      valid_i = 1'b1; addr_i = 32'(4 * k); wstrb_i = '0;
      tick();
      chk("b2b_valid_o", 64'(valid_o), 64'd1);
      chk("b2b_addr_o",  64'(addr_o),  64'(4 * k));
      ready_i = 1'b1; rdata_i = 32'hA0 + 32'(k);
      tick();
      ready_i = 1'b0; rdata_i = '0;
      chk("b2b_ready_o", 64'(ready_o), 64'd1);
      chk("b2b_rdata_o", 64'(rdata_o), 64'hA0 + 64'(k));
      valid_i = 1'b0;                         // bridge drops valid on ready
      tick();
      chk("b2b_ready_off", 64'(ready_o), 64'd0);
    end
    tick();
    tick();
    chk("b2b_no_dup_valid", 64'(valid_o), 64'd0);
    chk("b2b_req_count",  64'(req_edges - base_req),    64'd2);
    chk("b2b_resp_count", 64'(resp_pulses - base_resp), 64'd2);

`ifdef IOB_REQ_TIMEOUT_EN
    // ---- 5a: watchdog abort after 4 REQ cycles ----
    valid_i = 1'b1; addr_i = 32'h40; wstrb_i = '0;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_valid_o", 64'(valid_o), 64'd1);
      chk("to_ready_wait", 64'(ready_o), 64'd0);
      tick();
    end
    chk("to_ready_o", 64'(ready_o), 64'd1);
    chk("to_err_o",   64'(err_o),   64'd1);
    chk("to_rdata_o", 64'(rdata_o), 64'd0);
    chk("to_valid_off", 64'(valid_o), 64'd0);
    tick();
    chk("to_ready_end", 64'(ready_o), 64'd0);
    chk("to_err_end",   64'(err_o),   64'd0);
    ready_i = 1'b1; rdata_i = 32'h99999999;   // late answer for the aborted access
    tick();
    chk("to_late_ready", 64'(ready_o), 64'd0);
    ready_i = 1'b0; rdata_i = '0;
    tick();

    // ---- 5b: ready_i on the expiry cycle wins ----
    valid_i = 1'b1; addr_i = 32'h44; wstrb_i = '0;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tow_valid_o", 64'(valid_o), 64'd1);
      if (i == 3) begin
        ready_i = 1'b1; rdata_i = 32'hBEEF0004;
      end
      tick();
    end
    ready_i = 1'b0; rdata_i = '0;
    chk("tow_ready_o", 64'(ready_o), 64'd1);
    chk("tow_err_o",   64'(err_o),   64'd0);
    chk("tow_rdata_o", 64'(rdata_o), 64'hBEEF0004);
    tick();
`else
    // ---- 6b: no timeout without the watchdog ----
    base_resp = resp_pulses;
    valid_i = 1'b1; addr_i = 32'h40; wstrb_i = '0;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("nto_valid_o", 64'(valid_o), 64'd1);
    chk("nto_no_resp", 64'(resp_pulses - base_resp), 64'd0);
    ready_i = 1'b1; rdata_i = 32'hBEEF0040;
    tick();
    ready_i = 1'b0; rdata_i = '0;
    chk("nto_ready_o", 64'(ready_o), 64'd1);
    chk("nto_err_o",   64'(err_o),   64'd0);
    chk("nto_rdata_o", 64'(rdata_o), 64'hBEEF0040);
    tick();
`endif

    // ---- 4: reset while in REQ drops the access ----
    valid_i = 1'b1; addr_i = 32'h300; wstrb_i = '0;
    tick();
    chk("rr_valid_req", 64'(valid_o), 64'd1);
    valid_i = 1'b0; rst_i = 1'b1;
    tick();
    chk("rr_valid_o", 64'(valid_o), 64'd0);
    chk("rr_ready_o", 64'(ready_o), 64'd0);
    chk("rr_addr_o",  64'(addr_o),  64'd0);
    rst_i = 1'b0; ready_i = 1'b1; rdata_i = 32'h55555555;
    tick();
    chk("rr_late_ready1", 64'(ready_o), 64'd0);
    tick();
    chk("rr_late_ready2", 64'(ready_o), 64'd0);
    chk("rr_rdata_o",     64'(rdata_o), 64'd0);
    ready_i = 1'b0; rdata_i = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
